// File: rtl/mc_controller_pkg.sv
// Shared definitions for the multicycle main controller: opcodes, state encoding,
// datapath select codes and the per-state control word decode.
package mc_controller_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_OR    = 2'b10;
  localparam logic [1:0] ALUOP_FUNCT = 2'b11;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_BRIMM = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADR  = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWB   = 4'd5,
    S_MEMWR   = 4'd6,
    S_EXECUTE = 4'd7,
    S_ALUWB   = 4'd8,
    S_BRANCH  = 4'd9,
    S_ADDIEX  = 4'd10,
    S_ORIEX   = 4'd11,
    S_IWB     = 4'd12,
    S_JUMP    = 4'd13,
    S_TRAP    = 4'd14
  } state_e;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       iord;
    logic       ir_en;
    logic       pc_write;
    logic       branch;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       zext_imm;
    logic [1:0] pc_src;
    logic [1:0] aluop;
  } ctrl_t;

  // Moore control word for a state; ir_en/branch are qualified later by mem_ready/zero.
  function automatic ctrl_t ctrl_decode(state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_req   = 1'b1;
        c.ir_en     = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.aluop     = ALUOP_ADD;
        c.pc_src    = PCSRC_ALU;
      end
      S_DECODE: begin
        c.alu_src_b = SRCB_BRIMM;
        c.aluop     = ALUOP_ADD;
      end
      S_MEMADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        c.mem_req = 1'b1;
        c.iord    = 1'b1;
      end
      S_MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        c.mem_req   = 1'b1;
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      S_EXECUTE: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_REG;
        c.aluop     = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_REG;
        c.aluop     = ALUOP_SUB;
        c.pc_src    = PCSRC_ALUOUT;
        c.branch    = 1'b1;
      end
      S_ADDIEX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
      end
      S_ORIEX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.aluop     = ALUOP_OR;
        c.zext_imm  = 1'b1;
      end
      S_IWB: begin
        c.reg_write = 1'b1;
      end
      S_JUMP: begin
        c.pc_src   = PCSRC_JUMP;
        c.pc_write = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Watchdog for memory handshakes: counts consecutive wait cycles and flags the
// cycle in which the count would reach WAIT_LIMIT while still waiting.
module mc_wait_timer #(
  parameter int WAIT_LIMIT = 255,
  parameter int CNT_W      = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic inc_i,
  output logic expire_o
);

  localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(WAIT_LIMIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A ready in the expiry cycle suppresses inc_i, so completion wins over the error.
  assign expire_o = inc_i && (cnt_q == LIMIT_M1);

endmodule

// File: rtl/mc_controller.sv
// Multicycle main control FSM: sequences fetch..writeback, drives datapath enables
// and aluop for aludec, traps unknown opcodes and stalled memory accesses.
//
//  state   | meaning
//  IDLE    | post-reset, one cycle
//  FETCH   | read instruction at PC, PC+4
//  DECODE  | register read, branch target into ALUOut
//  MEMADR  | lw/sw effective address
//  MEMRD   | data read
//  MEMWB   | load writeback to rt
//  MEMWR   | data write
//  EXECUTE | R-type ALU op
//  ALUWB   | R-type writeback to rd
//  BRANCH  | beq compare and conditional PC update
//  ADDIEX  | addi ALU op
//  ORIEX   | ori ALU op, zero-extended immediate
//  IWB     | immediate writeback to rt
//  JUMP    | PC <= jump target
//  TRAP    | terminal until reset (illegal or bus_err)
module mc_controller
  import mc_controller_pkg::*;
#(
  parameter int WAIT_LIMIT = 255,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_en,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       zext_imm,
  output logic [1:0] pc_src,
  output logic [1:0] aluop,
  output logic       illegal,
  output logic       bus_err
);

  state_e state_q;
  state_e state_d;
  ctrl_t  ctrl_q;
  logic   illegal_q;
  logic   bus_err_q;
  logic   wait_state;
  logic   wd_expire;
  logic   illegal_set;

  assign wait_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);

  mc_wait_timer #(
    .WAIT_LIMIT(WAIT_LIMIT),
    .CNT_W     (CNT_W)
  ) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (!wait_state || mem_ready),
    .inc_i   (wait_state && !mem_ready),
    .expire_o(wd_expire)
  );

  always_comb begin
    state_d     = state_q;
    illegal_set = 1'b0;
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ready)      state_d = S_DECODE;
        else if (wd_expire) state_d = S_TRAP;
      end
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_ORI:       state_d = S_ORIEX;
          OP_J:         state_d = S_JUMP;
          default: begin
            state_d     = S_TRAP;
            illegal_set = 1'b1;
          end
        endcase
      end
      // op comes from the IR, which is held stable through the instruction.
      S_MEMADR: state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD: begin
        if (mem_ready)      state_d = S_MEMWB;
        else if (wd_expire) state_d = S_TRAP;
      end
      S_MEMWB: state_d = S_FETCH;
      S_MEMWR: begin
        if (mem_ready)      state_d = S_FETCH;
        else if (wd_expire) state_d = S_TRAP;
      end
      S_EXECUTE: state_d = S_ALUWB;
      S_ALUWB:   state_d = S_FETCH;
      S_BRANCH:  state_d = S_FETCH;
      S_ADDIEX:  state_d = S_IWB;
      S_ORIEX:   state_d = S_IWB;
      S_IWB:     state_d = S_FETCH;
      S_JUMP:    state_d = S_FETCH;
      S_TRAP:    state_d = S_TRAP;
      default:   state_d = S_TRAP;
    endcase
  end

  // Control word is registered from the next state so outputs stay glitch-free
  // and drop asynchronously with reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ctrl_q    <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_decode(state_d);
      illegal_q <= illegal_q | illegal_set;
      bus_err_q <= bus_err_q | wd_expire;
    end
  end

  assign mem_req    = ctrl_q.mem_req;
  assign mem_write  = ctrl_q.mem_write;
  assign iord       = ctrl_q.iord;
  assign ir_write   = ctrl_q.ir_en & mem_ready;
  assign pc_en      = ctrl_q.pc_write | (ctrl_q.ir_en & mem_ready) | (ctrl_q.branch & zero);
  assign reg_write  = ctrl_q.reg_write;
  assign reg_dst    = ctrl_q.reg_dst;
  assign mem_to_reg = ctrl_q.mem_to_reg;
  assign alu_src_a  = ctrl_q.alu_src_a;
  assign alu_src_b  = ctrl_q.alu_src_b;
  assign zext_imm   = ctrl_q.zext_imm;
  assign pc_src     = ctrl_q.pc_src;
  assign aluop      = ctrl_q.aluop;
  assign illegal    = illegal_q;
  assign bus_err    = bus_err_q;

endmodule
